ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit alongside the single-cycle execute ALU. It accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation at a time and computes it over XLEN cycles with a shift-add multiplier and a restoring divider. While an operation is in flight it holds `ex_stall` so the pipeline freezes. The result and destination register are returned with a one-cycle `done` pulse.

---
 rtl/ex_muldiv_pkg.sv | 47 ++++
 rtl/ex_md_abs.sv | 12 +
 rtl/ex_muldiv.sv | 181 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and decode helpers for the RV32M iterative multiply/divide unit.
package ex_muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_DONE
    } md_state_e;

    localparam logic [4:0] REG_ADDR_ZERO = '0;

    typedef struct packed {
        logic a_signed;
        logic b_signed;
    } op_sign_t;

    function automatic op_sign_t op_signedness(input logic [2:0] op);
        op_sign_t s;
        s = '0;
        case (md_op_e'(op))
            MD_MULH, MD_DIV, MD_REM: s = '{a_signed: 1'b1, b_signed: 1'b1};
            MD_MULHSU:               s = '{a_signed: 1'b1, b_signed: 1'b0};
            default:                 s = '0;
        endcase
        return s;
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/ex_md_abs.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix.
module ex_md_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? ((~value) + W'(1)) : value;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide: shift-add multiplier and restoring divider,
// one bit per cycle, stalling the pipeline while an operation is in flight.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] reg1,
    input  logic [XLEN-1:0] reg2,
    input  logic [4:0]      rd,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rd_data_o,
    output logic [4:0]      rd_addr,
    output logic            ex_stall
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state, state_next;
    logic [CW-1:0]   cnt;
    md_op_e          op_q;
    logic [4:0]      rd_q;
    logic            neg_q;
    logic [XLEN-1:0] acc_hi, acc_lo, opb_q;

    op_sign_t        sg;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    assign sg    = op_signedness(md_op);
    assign a_neg = sg.a_signed & reg1[XLEN-1];
    assign b_neg = sg.b_signed & reg2[XLEN-1];

    ex_md_abs #(.W(XLEN)) u_abs_a (.value(reg1), .negate(a_neg), .result(a_mag));
    ex_md_abs #(.W(XLEN)) u_abs_b (.value(reg2), .negate(b_neg), .result(b_mag));

    // Special cases resolved at issue without iterating.
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    assign div_zero = op_is_div(md_op) && (reg2 == '0);
    assign div_ovf  = ((md_op_e'(md_op) == MD_DIV) || (md_op_e'(md_op) == MD_REM))
                      && (reg1 == MIN_NEG) && (reg2 == '1);
    assign special  = div_zero | div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = op_is_rem(md_op) ? reg1 : '1;
        else
            special_res = op_is_rem(md_op) ? '0 : reg1;
    end

    // Multiply step: acc_hi:acc_lo is the product register, acc_lo starts as the multiplier.
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_n, mul_lo_n;

    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_q} : '0);
    assign mul_hi_n = mul_sum[XLEN:1];
    assign mul_lo_n = {mul_sum[0], acc_lo[XLEN-1:1]};

    // Divide step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    logic [XLEN:0]   div_diff;
    logic            div_ok;
    logic [XLEN-1:0] div_rem_n, div_quo_n;

    assign div_diff  = {acc_hi, acc_lo[XLEN-1]} - {1'b0, opb_q};
    assign div_ok    = ~div_diff[XLEN];
    assign div_rem_n = div_ok ? div_diff[XLEN-1:0] : {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
    assign div_quo_n = {acc_lo[XLEN-2:0], div_ok};

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, run_res;

    ex_md_abs #(.W(2*XLEN)) u_fix_prod (.value({mul_hi_n, mul_lo_n}), .negate(neg_q), .result(prod_fix));
    ex_md_abs #(.W(XLEN))   u_fix_quo  (.value(div_quo_n), .negate(neg_q), .result(quo_fix));
    ex_md_abs #(.W(XLEN))   u_fix_rem  (.value(div_rem_n), .negate(neg_q), .result(rem_fix));

    always_comb begin
        run_res = '0;
        case (op_q)
            MD_MUL:                      run_res = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: run_res = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             run_res = quo_fix;
            default:                     run_res = rem_fix;
        endcase
    end

    logic            accept, step, write_en;
    logic [XLEN-1:0] write_val;
    logic [4:0]      write_addr;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        write_en   = 1'b0;
        write_val  = '0;
        write_addr = rd_q;
        case (state)
            MD_IDLE: begin
                if (start && !flush) begin
                    if (special) begin
                        state_next = MD_DONE;
                        write_en   = 1'b1;
                        write_val  = special_res;
                        write_addr = rd;
                    end else begin
                        state_next = MD_RUN;
                        accept     = 1'b1;
                    end
                end
            end
            MD_RUN: begin
                if (flush) begin
                    state_next = MD_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CW'(XLEN - 1)) begin
                        state_next = MD_DONE;
                        write_en   = 1'b1;
                        write_val  = run_res;
                    end
                end
            end
            default: state_next = MD_IDLE;
        endcase
    end

    assign ex_stall = ~rst & (((state == MD_IDLE) & start) | (state == MD_RUN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MD_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_data_o <= '0;
            rd_addr   <= REG_ADDR_ZERO;
        end else begin
            state <= state_next;
            busy  <= (state_next == MD_RUN);
            done  <= (state_next == MD_DONE);
            if (write_en) begin
                rd_data_o <= write_val;
                rd_addr   <= write_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            op_q   <= MD_MUL;
            rd_q   <= REG_ADDR_ZERO;
            neg_q  <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            opb_q  <= '0;
        end else if (accept) begin
            cnt    <= '0;
            op_q   <= md_op_e'(md_op);
            rd_q   <= rd;
            neg_q  <= op_is_rem(md_op) ? a_neg : (a_neg ^ b_neg);
            acc_hi <= '0;
            acc_lo <= op_is_div(md_op) ? a_mag : b_mag;
            opb_q  <= op_is_div(md_op) ? b_mag : a_mag;
        end else if (step) begin
            cnt    <= cnt + CW'(1);
            acc_hi <= op_is_div(op_q) ? div_rem_n : mul_hi_n;
            acc_lo <= op_is_div(op_q) ? div_quo_n : mul_lo_n;
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv against a plain-arithmetic RV32M reference model.
module tb_ex_muldiv;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            flush = 1'b0;
    logic [2:0]      md_op = '0;
    logic [XLEN-1:0] reg1 = '0;
    logic [XLEN-1:0] reg2 = '0;
    logic [4:0]      rd = '0;
    logic            busy, done, ex_stall;
    logic [XLEN-1:0] rd_data_o;
    logic [4:0]      rd_addr;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [31:0] last_res = '0;

    ex_muldiv #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .md_op(md_op),
        .reg1(reg1), .reg2(reg2), .rd(rd), .flush(flush),
        .busy(busy), .done(done), .rd_data_o(rd_data_o),
        .rd_addr(rd_addr), .ex_stall(ex_stall)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = a;
        ib = b;
        case (op)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
        int lat, stall_cnt;
        logic special;
        logic [31:0] exp;
        exp     = ref_md(op, a, b);
        special = op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        @(negedge clk);
        md_op = op; reg1 = a; reg2 = b; rd = r; start = 1'b1;
        #1;
        stall_cnt = (ex_stall === 1'b1) ? 1 : 0;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (done === 1'b1) break;
            if (ex_stall === 1'b1) stall_cnt++;
        end
        check($sformatf("latency op%0d", op), 64'(lat), special ? 64'd1 : 64'd33);
        check($sformatf("result op%0d a=%h b=%h", op, a, b), 64'(rd_data_o), 64'(exp));
        check("rd_addr", 64'(rd_addr), 64'(r));
        check("stall_cycles", 64'(stall_cnt), special ? 64'd1 : 64'd33);
        check("stall_on_done", 64'(ex_stall), 64'd0);
        check("busy_on_done", 64'(busy), 64'd0);
        last_res = exp;
        @(posedge clk); #1;
        check("done_width", 64'(done), 64'd0);
    endtask

    initial begin
        int dc;
        logic [2:0] op;
        logic [31:0] a, b;

        // Reset state, with start held high to show ex_stall is masked by reset.
        start = 1'b1;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_data", 64'(rd_data_o), 64'd0);
        check("rst_addr", 64'(rd_addr), 64'd0);
        check("rst_stall", 64'(ex_stall), 64'd0);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3);
        check("mul_neg_const", 64'(rd_data_o), 64'hFFFF_FFEB);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd6);
        run_op(3'd4, 32'd100, 32'd0, 5'd7);
        run_op(3'd6, 32'd100, 32'd0, 5'd8);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd11);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd12);
        run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd13);
        run_op(3'd7, 32'hFFFF_FFF9, 32'd2, 5'd14);
        run_op(3'd5, 32'd55, 32'd0, 5'd15);
        run_op(3'd7, 32'd55, 32'd0, 5'd16);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: begin a = 32'h8000_0000; b = '1; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(op, a, b, 5'($urandom_range(0, 31)));
        end

        // Flush mid-RUN: no done, result unchanged.
        @(negedge clk);
        md_op = 3'd0; reg1 = 32'h1234_5678; reg2 = 32'h9; rd = 5'd20; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        dc = done_cnt;
        @(posedge clk); #1 flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_data", 64'(rd_data_o), 64'(last_res));
        repeat (40) @(posedge clk);
        #1;
        check("flush_no_done", 64'(done_cnt), 64'(dc));

        // Flush in IDLE blocks a simultaneous start.
        @(negedge clk);
        md_op = 3'd5; reg1 = 32'd50; reg2 = 32'd5; rd = 5'd21; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1 start = 1'b0; flush = 1'b0;
        check("idle_flush_busy", 64'(busy), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("idle_flush_no_done", 64'(done_cnt), 64'(dc));
        check("idle_flush_data", 64'(rd_data_o), 64'(last_res));

        // Second start during RUN is ignored.
        @(negedge clk);
        md_op = 3'd5; reg1 = 32'd1000; reg2 = 32'd7; rd = 5'd22; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        dc = done_cnt;
        repeat (5) @(posedge clk);
        @(negedge clk);
        md_op = 3'd0; reg1 = 32'd3; reg2 = 32'd3; rd = 5'd23; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        check("single_done", 64'(done_cnt - dc), 64'd1);
        check("ignored_start_data", 64'(rd_data_o), 64'(ref_md(3'd5, 32'd1000, 32'd7)));
        check("ignored_start_addr", 64'(rd_addr), 64'd22);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        md_op = 3'd4; reg1 = 32'hFFFF_0000; reg2 = 32'd3; rd = 5'd24; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_data", 64'(rd_data_o), 64'd0);
        check("arst_addr", 64'(rd_addr), 64'd0);
        check("arst_stall", 64'(ex_stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd6, 32'hFFFF_FF00, 32'd7, 5'd25);
        run_op(3'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 5'd26);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
